// File: rtl/gate_sweep_ctrl.sv
// Sweeps a 2-input gate through {A,B} = 00,10,11,01 and counts mismatches against the selected function.
// Optional first-mismatch log ports are enabled by defining GATE_SWEEP_ERRLOG_EN.
module gate_sweep_ctrl #(
   parameter int HOLD_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [1:0] op_sel,
   input  logic       gate_o,
   output logic       gate_a,
   output logic       gate_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt
`ifdef GATE_SWEEP_ERRLOG_EN
   ,
   output logic       fail_vld,
   output logic [1:0] fail_idx,
   output logic       fail_obs
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

   state_t     r_state;
   logic [3:0] r_hold;
   logic [1:0] r_idx;
   logic [1:0] r_op;
   logic       w_exp;
   logic       w_mis;
   logic [1:0] w_idx_nxt;

   // Index order 0..3 maps to {A,B} = 00,10,11,01 (a Gray sequence).
   function automatic logic vec_a(input logic [1:0] idx);
      return idx[1] ^ idx[0];
   endfunction

   function automatic logic vec_b(input logic [1:0] idx);
      return idx[1];
   endfunction

   assign w_idx_nxt = r_idx + 2'd1;

   always_comb begin
      w_exp = 1'b0;
      case (r_op)
         2'b00:   w_exp = gate_a | gate_b;
         2'b01:   w_exp = gate_a & gate_b;
         2'b10:   w_exp = gate_a ^ gate_b;
         default: w_exp = ~(gate_a & gate_b);
      endcase
      w_mis = (gate_o != w_exp);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_hold   <= 4'd0;
         r_idx    <= 2'd0;
         r_op     <= 2'd0;
         gate_a   <= 1'b0;
         gate_b   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= 3'd0;
`ifdef GATE_SWEEP_ERRLOG_EN
         fail_vld <= 1'b0;
         fail_idx <= 2'd0;
         fail_obs <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (r_state != S_IDLE && abort) begin
            // Cancel keeps the partial error count but never reports a pass.
            r_state <= S_IDLE;
            gate_a  <= 1'b0;
            gate_b  <= 1'b0;
            busy    <= 1'b0;
            pass    <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_state  <= S_APPLY;
                     r_op     <= op_sel;
                     r_idx    <= 2'd0;
                     r_hold   <= 4'd0;
                     err_cnt  <= 3'd0;
                     pass     <= 1'b0;
                     busy     <= 1'b1;
                     gate_a   <= vec_a(2'd0);
                     gate_b   <= vec_b(2'd0);
`ifdef GATE_SWEEP_ERRLOG_EN
                     fail_vld <= 1'b0;
                     fail_idx <= 2'd0;
                     fail_obs <= 1'b0;
`endif
                  end
               end
               S_APPLY: begin
                  if (r_hold == 4'(HOLD_CYC - 1)) r_state <= S_CHECK;
                  else                             r_hold  <= r_hold + 4'd1;
               end
               S_CHECK: begin
                  if (w_mis) err_cnt <= err_cnt + 3'd1;
`ifdef GATE_SWEEP_ERRLOG_EN
                  if (w_mis && !fail_vld) begin
                     fail_vld <= 1'b1;
                     fail_idx <= r_idx;
                     fail_obs <= gate_o;
                  end
`endif
                  if (r_idx == 2'd3) begin
                     // Last vector: fold this cycle's result into pass directly.
                     r_state <= S_DONE;
                     done    <= 1'b1;
                     pass    <= (err_cnt == 3'd0) && !w_mis;
                     gate_a  <= 1'b0;
                     gate_b  <= 1'b0;
                  end else begin
                     r_state <= S_APPLY;
                     r_idx   <= w_idx_nxt;
                     r_hold  <= 4'd0;
                     gate_a  <= vec_a(w_idx_nxt);
                     gate_b  <= vec_b(w_idx_nxt);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized self-checking bench for gate_sweep_ctrl against a truth-table gate model.
// Build with GATE_SWEEP_ERRLOG_EN defined to also check the first-mismatch log.
module tb_gate_sweep_ctrl;
   localparam int H   = 2;
   localparam int LAT = 4 * (H + 1) + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] op_sel = 2'b00;
   logic       gate_o;
   logic       gate_a, gate_b, busy, done, pass;
   logic [2:0] err_cnt;
   logic [3:0] gate_tt = 4'b1110;
`ifdef GATE_SWEEP_ERRLOG_EN
   logic       fail_vld;
   logic [1:0] fail_idx;
   logic       fail_obs;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   logic [1:0] vec [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   gate_sweep_ctrl #(.HOLD_CYC(H)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_sel(op_sel),
      .gate_o(gate_o), .gate_a(gate_a), .gate_b(gate_b), .busy(busy),
      .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef GATE_SWEEP_ERRLOG_EN
      , .fail_vld(fail_vld), .fail_idx(fail_idx), .fail_obs(fail_obs)
`endif
   );

   // Gate under test: arbitrary 2-input function as a truth table indexed by {A,B}.
   assign gate_o = gate_tt[{gate_a, gate_b}];

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic ref_gate(input logic [1:0] op, input logic a, input logic b);
      case (op)
         2'b00:   return a | b;
         2'b01:   return a & b;
         2'b10:   return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic check_idle_zero(input string tag);
      check({tag, "_gate"}, {30'd0, gate_a, gate_b}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_pass"}, {31'd0, pass}, 32'd0);
      check({tag, "_err"},  {29'd0, err_cnt}, 32'd0);
`ifdef GATE_SWEEP_ERRLOG_EN
      check({tag, "_flog"}, {28'd0, fail_vld, fail_idx, fail_obs}, 32'd0);
`endif
   endtask

   task automatic run_sweep(input logic [1:0] op, input logic [3:0] tt, input bit noise);
      int exp_err = 0;
      bit fv = 0;
      int fidx = 0;
      bit fobs = 0;
      int done_at = -1;
      int done_n = 0;
      for (int v = 0; v < 4; v++) begin
         if (tt[vec[v]] != ref_gate(op, vec[v][1], vec[v][0])) begin
            exp_err++;
            if (!fv) begin fv = 1; fidx = v; fobs = tt[vec[v]]; end
         end
      end
      @(negedge clk);
      start = 1'b1; op_sel = op; gate_tt = tt;
      for (int c = 1; c <= LAT + 3; c++) begin
         @(negedge clk);
         if (c <= 4 * (H + 1) && ((c - 1) % (H + 1)) < H)
            check("vec", {30'd0, gate_a, gate_b}, {30'd0, vec[(c - 1) / (H + 1)]});
         if (c == 1 || c == LAT) check("busy_hi", {31'd0, busy}, 32'd1);
         if (c == LAT + 1)       check("busy_lo", {31'd0, busy}, 32'd0);
         if (done) begin done_n++; if (done_at < 0) done_at = c; end
         if (noise && c <= LAT - 1) begin
            start = 1'($urandom_range(0, 1));
            op_sel = 2'($urandom_range(0, 3));
         end else begin
            start = 1'b0;
         end
      end
      check("done_at", done_at, LAT);
      check("done_n", done_n, 1);
      check("err_cnt", {29'd0, err_cnt}, exp_err);
      check("pass", {31'd0, pass}, {31'd0, exp_err == 0});
`ifdef GATE_SWEEP_ERRLOG_EN
      check("fail_vld", {31'd0, fail_vld}, {31'd0, fv});
      if (fv) check("fail_idx_obs", {29'd0, fail_idx, fail_obs}, {29'd0, 2'(fidx), fobs});
`endif
      $display("sweep op=%0d tt=%b noise=%0d err=%0d pass=%0d done_at=%0d",
               op, tt, noise, err_cnt, pass, done_at);
   endtask

   initial begin
      #2;
      check_idle_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_sweep(2'b00, 4'b1110, 1'b0);   // OR vs ideal OR
      run_sweep(2'b01, 4'b1110, 1'b0);   // AND vs OR: 2 errors
      run_sweep(2'b11, 4'b0000, 1'b0);   // NAND vs stuck-0: 3 errors
      run_sweep(2'b10, 4'b0110, 1'b0);   // XOR vs ideal XOR
      run_sweep(2'b00, 4'b1110, 1'b1);   // start/op_sel noise while busy
      for (int i = 0; i < 20; i++)
         run_sweep(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

      // Abort in APPLY of index 2: AND vs OR has one error so far (index 1).
      begin
         int done_n = 0;
         @(negedge clk);
         start = 1'b1; op_sel = 2'b01; gate_tt = 4'b1110;
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 7) begin
               check("abort_pre_vec", {30'd0, gate_a, gate_b}, {30'd0, vec[2]});
               abort = 1'b1;
            end
            if (c == 8) begin
               abort = 1'b0;
               check("abort_gate", {30'd0, gate_a, gate_b}, 32'd0);
               check("abort_busy", {31'd0, busy}, 32'd0);
               check("abort_err", {29'd0, err_cnt}, 32'd1);
               check("abort_pass", {31'd0, pass}, 32'd0);
`ifdef GATE_SWEEP_ERRLOG_EN
               check("abort_flog", {28'd0, fail_vld, fail_idx, fail_obs}, {28'd0, 1'b1, 2'd1, 1'b1});
`endif
            end
            if (done) done_n++;
         end
         check("abort_no_done", done_n, 0);
         $display("abort test err=%0d busy=%0d done_pulses=%0d", err_cnt, busy, done_n);
      end

      // Reset in CHECK of index 1, then a clean sweep after release.
      @(negedge clk);
      start = 1'b1; op_sel = 2'b01; gate_tt = 4'b1110;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_idle_zero("midrst");
      $display("mid-sweep reset applied");
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(2'b00, 4'b1110, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter HOLD_CYC, default 2, sets the number of cycles each input vector is driven before it is sampled; legal range 1..15.
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port start, input, 1, sweep request; sampled in IDLE only.
REQ-006 Port abort, input, 1, synchronous sweep cancel.
REQ-007 Port op_sel, input, 2, expected gate function: 00 OR, 01 AND, 10 XOR, 11 NAND.
REQ-008 Port gate_o, input, 1, output of the gate under test.
REQ-009 Port gate_a, output, 1, drives gate input A.
REQ-010 Port gate_b, output, 1, drives gate input B.
REQ-011 Port busy, output, 1, high while a sweep is in progress (APPLY, CHECK or DONE state).
REQ-012 Port done, output, 1, single-cycle pulse at sweep end.
REQ-013 Port pass, output, 1, high when err_cnt is 0; valid from done and held until the next accepted start.
REQ-014 Port err_cnt, output, 3, number of mismatching vectors, range 0..4.

Function
REQ-015 The vector order SHALL be fixed {A,B} = 00, 10, 11, 01, using a 2-bit index that runs 0..3 and does not wrap within a sweep.
REQ-016 The state machine SHALL have four states: IDLE, APPLY, CHECK, DONE.
REQ-017 In IDLE, start=1 SHALL latch op_sel, clear err_cnt and pass, set the vector index to 0 and enter APPLY on the next cycle.
REQ-018 In APPLY, gate_a and gate_b SHALL present the current vector for HOLD_CYC consecutive cycles, then the state SHALL advance to CHECK.
REQ-019 In CHECK (one cycle), gate_o SHALL be compared with the latched-op expected value for the vector; a mismatch SHALL increment err_cnt.
REQ-020 Leaving CHECK SHALL go to APPLY with index+1, or to DONE when the index is 3.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, pass SHALL be updated, and the next state SHALL be IDLE.
REQ-022 The start-to-done latency SHALL be exactly 4*(HOLD_CYC+1)+1 cycles after the start edge.
REQ-023 start asserted while busy SHALL be ignored, and op_sel changes during a sweep SHALL have no effect.
REQ-024 abort=1 in any non-IDLE state SHALL return to IDLE on the next edge with gate_a=gate_b=0, busy=0 and no done pulse; err_cnt SHALL hold its partial value and pass SHALL be 0.
REQ-025 abort takes priority over start when both are high in the same cycle; in IDLE, abort SHALL have no effect.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force IDLE, with gate_a, gate_b, busy, done, pass and err_cnt all 0, plus the hold counter, index and latched op all cleared, including mid-sweep.
REQ-028 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Configuration
REQ-029 Macro GATE_SWEEP_ERRLOG_EN: when defined, the block SHALL add outputs fail_vld (1), fail_idx (2) and fail_obs (1), capturing the index and observed gate_o of the first mismatch in a sweep; these are cleared on accepted start and on reset, and held after done.
REQ-030 Without GATE_SWEEP_ERRLOG_EN, these ports and their registers SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-031 HOLD_CYC=2, op_sel=00, ideal OR model, start pulse -> vectors 00, 10, 11, 01 are each held 2 cycles; done at cycle 13; err_cnt=0; pass=1.
REQ-032 op_sel=01 (AND) against an OR model -> err_cnt=2 (vectors 10 and 01); pass=0; with ERRLOG_EN, fail_idx=1 and fail_obs=1.
REQ-033 gate_o stuck at 0, op_sel=11 (NAND) -> err_cnt=3; pass=0; with ERRLOG_EN, fail_idx=0 and fail_obs=0.
REQ-034 abort asserted in APPLY of index 2 -> IDLE next cycle; gate_a=gate_b=0; busy=0; done never pulses.
REQ-035 start re-pulsed while busy, and op_sel changed mid-sweep -> latency and result match REQ-031 exactly.
REQ-036 rst_n pulled low in CHECK of index 1 -> all outputs are 0 immediately; a new start after release runs a full clean sweep.
